pdl_array: RTL and testbench

PDL_ARRAY -- requirements
Module: pdl_array

---
 rtl/pdl_array_if.sv | 20 ++
 rtl/pdl_array.sv | 155 +++++++++++++++
 tb/tb_pdl_array.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pdl_array_if.sv
// Paddle array bus: per-paddle buttons, freeze and scan position in;
// paddle centres, hit flags and hit colour out.
`timescale 1ns/1ps
interface pdl_array_if #(parameter int NUM_PDL = 2);
  logic [NUM_PDL-1:0]    btn_up;
  logic [NUM_PDL-1:0]    btn_dn;
  logic                  freeze;
  logic [9:0]            x;
  logic [9:0]            y;
  logic [10*NUM_PDL-1:0] x_pdl;
  logic [10*NUM_PDL-1:0] y_pdl;
  logic [NUM_PDL-1:0]    pdl_on;
  logic                  any_on;
  logic [11:0]           rgb_pdl;

  modport master (output btn_up, btn_dn, freeze, x, y,
                  input  x_pdl, y_pdl, pdl_on, any_on, rgb_pdl);
  modport slave  (input  btn_up, btn_dn, freeze, x, y,
                  output x_pdl, y_pdl, pdl_on, any_on, rgb_pdl);
endinterface

// File: rtl/pdl_array.sv
// Array of independently driven paddles: button sync, IDLE/SLOW/FAST
// acceleration FSM, clamped vertical motion and per-pixel hit/colour.
`timescale 1ns/1ps
module pdl_lane #(
    parameter int IDX        = 0,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int PDL_W      = 16,
    parameter int PDL_H      = 80,
    parameter int EDGE_GAP   = 20,
    parameter int LANE_GAP   = 64,
    parameter int SPEED_SLOW = 1,
    parameter int SPEED_FAST = 4,
    parameter int HOLD_TICKS = 100
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       freeze,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [9:0] x_pdl,
    output logic [9:0] y_pdl,
    output logic       pdl_on
);
    localparam int XC_I = (IDX % 2 == 0) ? EDGE_GAP + PDL_W/2 + LANE_GAP*(IDX/2)
                                         : H_ACTIVE - (EDGE_GAP + PDL_W/2 + LANE_GAP*(IDX/2));
    localparam logic [10:0] XC    = 11'(XC_I);
    localparam logic [10:0] HW    = 11'(PDL_W/2);
    localparam logic [10:0] HH    = 11'(PDL_H/2);
    localparam logic [10:0] Y_MIN = 11'(PDL_H/2);
    localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - PDL_H/2);
    localparam logic [10:0] Y_RST = 11'(V_ACTIVE/2);
    localparam int CW = ($clog2(HOLD_TICKS+1) > 8) ? $clog2(HOLD_TICKS+1) : 8;
    // Counter value on the last SLOW tick: entry step plus HOLD_TICKS-1 held ticks.
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_TICKS-2);

    typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;
    typedef enum logic [1:0] {D_NONE, D_UP, D_DN} dir_t;

    logic [1:0]    up_ff, dn_ff;
    logic          up_s, dn_s;
    dir_t          dir, cur_dir;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [10:0]   y_q, spd, y_up, y_dn;
    logic          at_lim;

    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            up_ff <= 2'b11;
            dn_ff <= 2'b11;
        end else begin
            up_ff <= {up_ff[0], btn_up};
            dn_ff <= {dn_ff[0], btn_dn};
        end
    end

    assign up_s = ~up_ff[1];
    assign dn_s = ~dn_ff[1];

    always_comb begin
        dir = D_NONE;
        if (up_s && !dn_s)      dir = D_UP;
        else if (dn_s && !up_s) dir = D_DN;
        spd    = (state == FAST && dir == cur_dir) ? 11'(SPEED_FAST) : 11'(SPEED_SLOW);
        y_up   = (y_q >= Y_MIN + spd) ? y_q - spd : Y_MIN;
        y_dn   = (y_q + spd <= Y_MAX) ? y_q + spd : Y_MAX;
        // Pushing against a limit freezes the whole lane, not just y.
        at_lim = (dir == D_UP && y_q == Y_MIN) || (dir == D_DN && y_q == Y_MAX);
    end

    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cur_dir <= D_NONE;
            cnt     <= '0;
            y_q     <= Y_RST;
        end else if (!freeze && !at_lim) begin
            if (dir == D_NONE) begin
                state <= IDLE;
            end else begin
                y_q     <= (dir == D_UP) ? y_up : y_dn;
                cur_dir <= dir;
                if (state == IDLE || dir != cur_dir) begin
                    state <= SLOW;
                    cnt   <= '0;
                end else if (state == SLOW) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= FAST;
                end
            end
        end
    end

    assign x_pdl  = XC[9:0];
    assign y_pdl  = y_q[9:0];
    assign pdl_on = ({1'b0, x} >= XC - HW) && ({1'b0, x} < XC + HW) &&
                    ({1'b0, y} >= y_q - HH) && ({1'b0, y} < y_q + HH);
endmodule

module pdl_array #(
    parameter int          NUM_PDL    = 2,
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter int          PDL_W      = 16,
    parameter int          PDL_H      = 80,
    parameter int          EDGE_GAP   = 20,
    parameter int          LANE_GAP   = 64,
    parameter int          SPEED_SLOW = 1,
    parameter int          SPEED_FAST = 4,
    parameter int          HOLD_TICKS = 100,
    parameter logic [47:0] PALETTE    = 48'hF0F_0F0_00F_F00
) (
    input logic        clk_1ms,
    input logic        reset,
    pdl_array_if.slave bus
);
    logic [NUM_PDL-1:0][9:0] xp, yp;
    logic [NUM_PDL-1:0]      on;
    logic [11:0]             rgb;

    for (genvar i = 0; i < NUM_PDL; i++) begin : g_lane
        pdl_lane #(
            .IDX(i), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
            .PDL_W(PDL_W), .PDL_H(PDL_H), .EDGE_GAP(EDGE_GAP), .LANE_GAP(LANE_GAP),
            .SPEED_SLOW(SPEED_SLOW), .SPEED_FAST(SPEED_FAST), .HOLD_TICKS(HOLD_TICKS)
        ) u_lane (
            .clk_1ms(clk_1ms),
            .reset  (reset),
            .btn_up (bus.btn_up[i]),
            .btn_dn (bus.btn_dn[i]),
            .freeze (bus.freeze),
            .x      (bus.x),
            .y      (bus.y),
            .x_pdl  (xp[i]),
            .y_pdl  (yp[i]),
            .pdl_on (on[i])
        );
    end

    // Descending scan so the lowest-index hit wins.
    always_comb begin
        rgb = '0;
        for (int i = NUM_PDL-1; i >= 0; i--)
            if (on[i]) rgb = PALETTE[12*i +: 12];
    end

    assign bus.x_pdl   = xp;
    assign bus.y_pdl   = yp;
    assign bus.pdl_on  = on;
    assign bus.any_on  = |on;
    assign bus.rgb_pdl = rgb;
endmodule

// File: tb/tb_pdl_array.sv
// Directed bench for pdl_array: a step-level motion model checked every
// cycle, plus hand-computed literal positions and scan hits.
`timescale 1ns/1ps
module tb_pdl_array;
    localparam int NP = 2;
    localparam logic [47:0] PAL = 48'hF0F_0F0_00F_F00;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    pdl_array_if #(.NUM_PDL(NP)) bus ();
    pdl_array #(.NUM_PDL(NP)) dut (.clk_1ms(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Model: position, mode (0 idle, 1 slow, 2 fast), direction (-1/0/+1),
    // slow steps taken in the current run, and the 2-sample button delay line.
    int m_y[NP], m_mode[NP], m_dir[NP], m_slow[NP];
    bit hu1[NP], hu2[NP], hd1[NP], hd2[NP];
    int xc[NP] = '{28, 612};

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int p = 0; p < NP; p++) begin
            m_y[p] = 240; m_mode[p] = 0; m_dir[p] = 0; m_slow[p] = 0;
            hu1[p] = 1; hu2[p] = 1; hd1[p] = 1; hd2[p] = 1;
        end
    endtask

    task automatic model_step();
        if (reset) begin m_reset(); return; end
        for (int p = 0; p < NP; p++) begin
            bit up, dn, fresh;
            int d, sp, ny;
            up = !hu2[p]; dn = !hd2[p];
            hu2[p] = hu1[p]; hu1[p] = bus.btn_up[p];
            hd2[p] = hd1[p]; hd1[p] = bus.btn_dn[p];
            d = (up && !dn) ? -1 : ((dn && !up) ? 1 : 0);
            if (bus.freeze) continue;
            if (d == 0) begin m_mode[p] = 0; continue; end
            if ((d < 0 && m_y[p] == 40) || (d > 0 && m_y[p] == 440)) continue;
            fresh = (m_mode[p] == 0) || (d != m_dir[p]);
            sp = (!fresh && m_mode[p] == 2) ? 4 : 1;
            ny = m_y[p] + d*sp;
            if (ny < 40)  ny = 40;
            if (ny > 440) ny = 440;
            m_y[p] = ny;
            m_dir[p] = d;
            if (fresh) begin m_mode[p] = 1; m_slow[p] = 1; end
            else if (m_mode[p] == 1) begin
                m_slow[p]++;
                if (m_slow[p] == 100) m_mode[p] = 2;
            end
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    function automatic int ypos(input int p);
        return int'(bus.y_pdl[10*p +: 10]);
    endfunction

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        if (!reset) begin
            int first, ex_on;
            first = -1;
            for (int p = 0; p < NP; p++) begin
                ex_on = (int'(bus.x) >= xc[p]-8 && int'(bus.x) <= xc[p]+7 &&
                         int'(bus.y) >= m_y[p]-40 && int'(bus.y) <= m_y[p]+39) ? 1 : 0;
                if (ex_on == 1 && first < 0) first = p;
                chk("y_pdl", ypos(p), m_y[p]);
                chk("x_pdl", int'(bus.x_pdl[10*p +: 10]), xc[p]);
                chk("pdl_on", int'(bus.pdl_on[p]), ex_on);
            end
            chk("any_on", int'(bus.any_on), (first >= 0) ? 1 : 0);
            chk("rgb_pdl", int'(bus.rgb_pdl), (first >= 0) ? int'(PAL[12*first +: 12]) : 0);
        end
    end

    initial begin
        bus.btn_up = '1; bus.btn_dn = '1; bus.freeze = 1'b0;
        bus.x = '0; bus.y = '0;
        m_reset();
        tick(3);
        chk("reset_y0", ypos(0), 240);
        chk("reset_y1", ypos(1), 240);
        reset = 1'b0;

        // Hold up on paddle 0: first step on the 3rd tick, FAST after 100 SLOW steps.
        tick(2);
        bus.btn_up[0] = 1'b0;
        tick(2);
        chk("sync_delay_y0", ypos(0), 240);
        tick(1);
        chk("first_step_y0", ypos(0), 239);
        tick(99);
        chk("slow_end_y0", ypos(0), 140);
        tick(1);
        chk("fast1_y0", ypos(0), 136);
        tick(1);
        chk("fast2_y0", ypos(0), 132);

        // Top limit: 44 -> 40, hold, then down to 41.
        tick(22);
        chk("pre_lim_y0", ypos(0), 44);
        tick(1);
        chk("lim_y0", ypos(0), 40);
        tick(3);
        chk("lim_hold_y0", ypos(0), 40);
        bus.btn_up[0] = 1'b1; bus.btn_dn[0] = 1'b0;
        tick(2);
        chk("lim_turn_wait", ypos(0), 40);
        tick(1);
        chk("lim_turn_y0", ypos(0), 41);

        // Both buttons: hold, then release down -> SLOW step up.
        bus.btn_up[0] = 1'b0;
        tick(5);
        chk("both_hold_y0", ypos(0), 43);
        bus.btn_dn[0] = 1'b1;
        tick(3);
        chk("both_release_y0", ypos(0), 42);
        bus.btn_up[0] = 1'b1;
        tick(3);

        // Simultaneous presses on both paddles.
        reset = 1'b1; m_reset();
        tick(2);
        reset = 1'b0;
        bus.btn_up[0] = 1'b0; bus.btn_dn[1] = 1'b0;
        tick(3);
        chk("concur_y0", ypos(0), 239);
        chk("concur_y1", ypos(1), 241);
        tick(100);
        chk("concur_fast_y0", ypos(0), 136);
        chk("concur_fast_y1", ypos(1), 344);

        // Freeze during FAST, resume at -4 with no SLOW phase.
        bus.freeze = 1'b1;
        tick(10);
        chk("freeze_y0", ypos(0), 136);
        bus.freeze = 1'b0;
        tick(1);
        chk("resume_y0", ypos(0), 132);
        chk("resume_y1", ypos(1), 348);
        tick(30);
        chk("bot_lim_y1", ypos(1), 440);

        // Reset mid-move acts immediately; motion needs a fresh sync.
        tick(1);
        bus.btn_dn[1] = 1'b1;
        tick(50);
        reset = 1'b1; m_reset();
        #1;
        chk("async_rst_y0", ypos(0), 240);
        tick(2);
        reset = 1'b0;
        tick(2);
        chk("post_rst_wait", ypos(0), 240);
        tick(1);
        chk("post_rst_step", ypos(0), 239);
        bus.btn_up[0] = 1'b1;
        reset = 1'b1; m_reset();
        tick(1);
        reset = 1'b0;
        tick(1);

        // Scan hits; paddle 0 colour is PALETTE[11:0].
        bus.x = 10'd20; bus.y = 10'd200; #1;
        chk("scan_hit_on", int'(bus.pdl_on[0]), 1);
        chk("scan_hit_rgb", int'(bus.rgb_pdl), 12'hF00);
        bus.x = 10'd36; #1;
        chk("scan_x_miss", int'(bus.pdl_on[0]), 0);
        chk("scan_x_miss_rgb", int'(bus.rgb_pdl), 0);
        bus.x = 10'd20; bus.y = 10'd280; #1;
        chk("scan_y_miss", int'(bus.pdl_on[0]), 0);
        bus.x = 10'd619; bus.y = 10'd279; #1;
        chk("scan_p1_on", int'(bus.pdl_on), 2);
        chk("scan_p1_rgb", int'(bus.rgb_pdl), 12'h00F);
        chk("scan_p1_any", int'(bus.any_on), 1);
        bus.x = 10'd620; #1;
        chk("scan_p1_miss", int'(bus.any_on), 0);
        tick(2);
        bus.x = 10'd604; bus.y = 10'd200;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
